// File: rtl/knn_sdram_arbiter_if.sv
// Requester-side and SDRAM-side signal bundle for knn_sdram_arbiter.
// The arbiter connects through the slave modport; the requesters and memory connect through master.
interface knn_sdram_arbiter_if #(
    parameter int CH     = 4,
    parameter int W      = 16,
    parameter int ADDR_W = 25
);
    localparam int GW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]        ch_req;
    logic [CH-1:0]        ch_we;
    logic [CH*ADDR_W-1:0] ch_addr;
    logic [CH*W-1:0]      ch_wdata;
    logic [CH-1:0]        ch_done;
    logic [W-1:0]         ch_rdata;
    logic [GW-1:0]        grant_id;
    logic                 busy;
    logic                 read;
    logic [ADDR_W-1:0]    readaddress;
    logic [W-1:0]         readdata;
    logic                 write;
    logic [ADDR_W-1:0]    writeaddress;
    logic [W-1:0]         writedata;

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, readdata,
        output ch_done, ch_rdata, grant_id, busy,
               read, readaddress, write, writeaddress, writedata
    );

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, readdata,
        input  ch_done, ch_rdata, grant_id, busy,
               read, readaddress, write, writeaddress, writedata
    );
endinterface

// File: rtl/knn_sdram_arbiter.sv
// Round-robin arbiter serialising CH requesters onto one SDRAM read/write port,
// one transaction at a time through IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
module knn_sdram_arbiter #(
    parameter int CH      = 4,
    parameter int W       = 16,
    parameter int ADDR_W  = 25,
    parameter int RD_LAT  = 1,
    parameter int WR_WAIT = 9
) (
    input  logic               clk,
    input  logic               rst,
    knn_sdram_arbiter_if.slave bus
);
    localparam int GW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int LMAX = (RD_LAT > WR_WAIT) ? RD_LAT : WR_WAIT;
    localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;

    localparam logic [CW-1:0] RD_LOAD  = CW'(RD_LAT - 32'sd1);
    localparam logic [CW-1:0] WR_LOAD  = CW'(WR_WAIT - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [GW-1:0] GID_ONE  = GW'(32'd1);
    localparam logic [GW-1:0] LAST_CH  = GW'(CH - 32'sd1);
    localparam bit            WR_SKIP  = (WR_WAIT == 32'sd0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [GW-1:0]     p_r;
    logic [GW-1:0]     grant_id_r;
    logic              we_r;
    logic [CW-1:0]     cnt_r;
    logic              read_r;
    logic              write_r;
    logic [ADDR_W-1:0] readaddress_r;
    logic [ADDR_W-1:0] writeaddress_r;
    logic [W-1:0]      writedata_r;
    logic [CH-1:0]     done_r;
    logic [W-1:0]      rdata_r;
    logic              busy_r;

    logic              found_s;
    logic              hit_s;
    logic [GW-1:0]     win_s;
    logic              sel_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [W-1:0]      win_wdata_s;
    logic [CH-1:0]     done_vec_s;

    // Round-robin pick: first requester at or above p_r, otherwise the lowest one below it.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        win_s   = '0;
        for (int c = 0; c < CH; c++) begin
            hit_s   = !found_s && bus.ch_req[c] && (GW'(c) >= p_r);
            win_s   = hit_s ? GW'(c) : win_s;
            found_s = found_s | hit_s;
        end
        for (int c = 0; c < CH; c++) begin
            hit_s   = !found_s && bus.ch_req[c];
            win_s   = hit_s ? GW'(c) : win_s;
            found_s = found_s | hit_s;
        end
    end

    // Select the winning channel's direction, address and write data.
    always_comb begin
        sel_s       = 1'b0;
        win_we_s    = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        for (int c = 0; c < CH; c++) begin
            sel_s       = (win_s == GW'(c));
            win_we_s    = win_we_s | (sel_s & bus.ch_we[c]);
            win_addr_s  = win_addr_s | (bus.ch_addr[c*ADDR_W +: ADDR_W] & {ADDR_W{sel_s}});
            win_wdata_s = win_wdata_s | (bus.ch_wdata[c*W +: W] & {W{sel_s}});
        end
    end

    // One-hot completion vector for the granted channel.
    always_comb begin
        done_vec_s = '0;
        for (int c = 0; c < CH; c++) begin
            done_vec_s[c] = (grant_id_r == GW'(c));
        end
    end

    // Next-state logic; a zero write wait skips WAIT entirely.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = found_s ? ISSUE : IDLE;
            ISSUE: begin
                if (we_r && WR_SKIP) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            WAIT:    state_nx_s = (cnt_r == '0) ? DONE : WAIT;
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, grant bookkeeping and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            p_r            <= '0;
            grant_id_r     <= '0;
            we_r           <= 1'b0;
            cnt_r          <= '0;
            read_r         <= 1'b0;
            write_r        <= 1'b0;
            readaddress_r  <= '0;
            writeaddress_r <= '0;
            writedata_r    <= '0;
            done_r         <= '0;
            rdata_r        <= '0;
            busy_r         <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_nx_s == DONE) ? done_vec_s : '0;
            read_r  <= (state_r == IDLE) && found_s && !win_we_s;
            write_r <= (state_r == IDLE) && found_s && win_we_s;

            if ((state_r == IDLE) && found_s) begin
                grant_id_r <= win_s;
                we_r       <= win_we_s;
                p_r        <= (win_s == LAST_CH) ? '0 : (win_s + GID_ONE);
                if (win_we_s) begin
                    writeaddress_r <= win_addr_s;
                    writedata_r    <= win_wdata_s;
                end else begin
                    readaddress_r  <= win_addr_s;
                end
            end

            if (state_r == ISSUE) begin
                cnt_r <= we_r ? WR_LOAD : RD_LOAD;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - CNT_ONE;
            end

            // Memory data is taken on the edge that ends the last wait cycle.
            if ((state_r == WAIT) && (cnt_r == '0) && !we_r) begin
                rdata_r <= bus.readdata;
            end
        end
    end

    assign bus.read         = read_r;
    assign bus.write        = write_r;
    assign bus.readaddress  = readaddress_r;
    assign bus.writeaddress = writeaddress_r;
    assign bus.writedata    = writedata_r;
    assign bus.ch_done      = done_r;
    assign bus.ch_rdata     = rdata_r;
    assign bus.grant_id     = grant_id_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_knn_sdram_arbiter.sv
// Directed bench for knn_sdram_arbiter: a 4-channel instance (RD_LAT 1, WR_WAIT 9)
// and a 1-channel instance (RD_LAT 3, WR_WAIT 0), with hand-computed expectations.
module tb_knn_sdram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knn_sdram_arbiter_if #(.CH(4), .W(16), .ADDR_W(25)) ia ();
    knn_sdram_arbiter_if #(.CH(1), .W(16), .ADDR_W(25)) ib ();

    knn_sdram_arbiter #(.CH(4), .W(16), .ADDR_W(25), .RD_LAT(1), .WR_WAIT(9)) u_a (
        .clk(clk), .rst(rst), .bus(ia.slave));
    knn_sdram_arbiter #(.CH(1), .W(16), .ADDR_W(25), .RD_LAT(3), .WR_WAIT(0)) u_b (
        .clk(clk), .rst(rst), .bus(ib.slave));

    int n_chk = 0;
    int n_err = 0;
    int both_cnt = 0;
    int multi_cnt = 0;

    logic [31:0] a_rd_v, a_wr_v, a_busy_v, a_dn_v;
    logic [31:0] b_rd_v, b_wr_v, b_busy_v, b_dn_v;
    logic [3:0]  a_done_l  [32];
    logic [1:0]  a_gid_l   [32];
    logic [24:0] a_raddr_l [32];
    logic [24:0] a_waddr_l [32];
    logic [15:0] a_wdata_l [32];
    logic [15:0] a_rdata_l [32];
    logic [24:0] b_raddr_l [32];
    logic [24:0] b_waddr_l [32];
    logic [15:0] b_wdata_l [32];
    logic [15:0] b_rdata_l [32];

    function automatic logic [15:0] mem_val(input logic [24:0] a);
        return (a == 25'h40) ? 16'h1234 : (a[15:0] ^ 16'hA5A5);
    endfunction

    // Memory model: data appears the cycle after the read pulse and is held.
    always @(posedge clk) begin
        if (ia.read) ia.readdata <= mem_val(ia.readaddress);
        if (ib.read) ib.readdata <= mem_val(ib.readaddress);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nth_set(input logic [31:0] v, input int n);
        int k = 0;
        int r = -1;
        for (int i = 0; i < 32; i++) begin
            if (v[i] && r < 0) begin
                if (k == n) r = i;
                k++;
            end
        end
        return r;
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ia.ch_req = 4'b0000;
        ib.ch_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Sample n cycles at the falling edge; optionally drop each served request.
    task automatic observe(input int n, input bit drop);
        a_rd_v = '0; a_wr_v = '0; a_busy_v = '0; a_dn_v = '0;
        b_rd_v = '0; b_wr_v = '0; b_busy_v = '0; b_dn_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_rd_v[i] = ia.read;   a_wr_v[i] = ia.write;
            a_busy_v[i] = ia.busy; a_dn_v[i] = |ia.ch_done;
            a_done_l[i] = ia.ch_done;      a_gid_l[i] = ia.grant_id;
            a_raddr_l[i] = ia.readaddress; a_waddr_l[i] = ia.writeaddress;
            a_wdata_l[i] = ia.writedata;   a_rdata_l[i] = ia.ch_rdata;
            b_rd_v[i] = ib.read;   b_wr_v[i] = ib.write;
            b_busy_v[i] = ib.busy; b_dn_v[i] = ib.ch_done[0];
            b_raddr_l[i] = ib.readaddress; b_waddr_l[i] = ib.writeaddress;
            b_wdata_l[i] = ib.writedata;   b_rdata_l[i] = ib.ch_rdata;
            if (ia.read && ia.write) both_cnt++;
            if (ib.read && ib.write) both_cnt++;
            if ($countones(ia.ch_done) > 1) multi_cnt++;
            if (drop) begin
                ia.ch_req = ia.ch_req & ~ia.ch_done;
                ib.ch_req = ib.ch_req & ~ib.ch_done;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (ia.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(ia.busy), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ia.ch_req = 4'b0000; ia.ch_we = 4'b0000; ia.ch_addr = '0; ia.ch_wdata = '0;
        ib.ch_req = 1'b0;    ib.ch_we = 1'b0;    ib.ch_addr = '0; ib.ch_wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_read",  32'(ia.read), 32'd0);
        check("rst_write", 32'(ia.write), 32'd0);
        check("rst_raddr", 32'(ia.readaddress), 32'd0);
        check("rst_waddr", 32'(ia.writeaddress), 32'd0);
        check("rst_wdata", 32'(ia.writedata), 32'd0);
        check("rst_done",  32'(ia.ch_done), 32'd0);
        check("rst_rdata", 32'(ia.ch_rdata), 32'd0);
        check("rst_gid",   32'(ia.grant_id), 32'd0);
        check("rst_busy",  32'(ia.busy), 32'd0);

        // Single read, channel 0 at 0x40
        align();
        rst = 1'b1;
        ia.ch_we = 4'b0000;
        ia.ch_addr[0*25 +: 25] = 25'h40;
        ia.ch_req = 4'b0001;
        observe(6, 1'b1);
        check("rd_pulse_count", $countones(a_rd_v), 32'd1);
        check("rd_pulse_cycle", nth_set(a_rd_v, 0), 32'd1);
        check("rd_addr",        32'(a_raddr_l[1]), 32'h40);
        check("rd_gid",         32'(a_gid_l[1]), 32'd0);
        check("rd_done_cycle",  nth_set(a_dn_v, 0), 32'd3);
        check("rd_done_val",    32'(a_done_l[3]), 32'h1);
        check("rd_rdata",       32'(a_rdata_l[3]), 32'h1234);
        check("rd_busy_cycles", $countones(a_busy_v), 32'd3);
        check("rd_no_write",    $countones(a_wr_v), 32'd0);

        // No request: stays idle
        align();
        observe(3, 1'b0);
        check("idle_busy", $countones(a_busy_v), 32'd0);
        check("idle_rd",   $countones(a_rd_v), 32'd0);

        // Single write, channel 2: 0xBEEF at 0x100
        align();
        ia.ch_we = 4'b0100;
        ia.ch_addr[2*25 +: 25] = 25'h100;
        ia.ch_wdata[2*16 +: 16] = 16'hBEEF;
        ia.ch_req = 4'b0100;
        observe(14, 1'b1);
        check("wr_pulse_count", $countones(a_wr_v), 32'd1);
        check("wr_pulse_cycle", nth_set(a_wr_v, 0), 32'd1);
        check("wr_addr",        32'(a_waddr_l[1]), 32'h100);
        check("wr_data",        32'(a_wdata_l[1]), 32'hBEEF);
        check("wr_addr_done",   32'(a_waddr_l[11]), 32'h100);
        check("wr_busy_cycles", $countones(a_busy_v), 32'd11);
        check("wr_done_cycle",  nth_set(a_dn_v, 0), 32'd11);
        check("wr_done_val",    32'(a_done_l[11]), 32'h4);
        check("wr_gid",         32'(a_gid_l[11]), 32'd2);
        check("wr_rdata_held",  32'(a_rdata_l[11]), 32'h1234);

        // Fairness: all four requesting continuously after reset
        do_reset();
        ia.ch_we = 4'b0000;
        for (int c = 0; c < 4; c++) ia.ch_addr[c*25 +: 25] = 25'(32'h10 * c);
        ia.ch_req = 4'b1111;
        observe(22, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_done_cycle%0d", k), nth_set(a_dn_v, k), 32'(3 + 4 * k));
            check($sformatf("rr_gid%0d", k), 32'(a_gid_l[3 + 4 * k]), 32'(k % 4));
            check($sformatf("rr_done%0d", k), 32'(a_done_l[3 + 4 * k]), 32'(1 << (k % 4)));
        end
        ia.ch_req = 4'b0000;
        wait_idle("rr_drain");

        // Back-to-back reads on channels 0 and 1
        do_reset();
        ia.ch_addr[0*25 +: 25] = 25'h55;
        ia.ch_addr[1*25 +: 25] = 25'h66;
        ia.ch_req = 4'b0011;
        observe(12, 1'b1);
        check("b2b_pulses",   $countones(a_rd_v), 32'd2);
        check("b2b_first",    nth_set(a_rd_v, 0), 32'd1);
        check("b2b_second",   nth_set(a_rd_v, 1), 32'd5);
        check("b2b_addr2",    32'(a_raddr_l[5]), 32'h66);
        check("b2b_done2",    32'(a_done_l[7]), 32'h2);
        check("b2b_rdata2",   32'(a_rdata_l[7]), 32'(mem_val(25'h66)));

        // Reset in the third WAIT cycle of a write on channel 0
        align();
        ia.ch_we = 4'b0001;
        ia.ch_addr[0*25 +: 25] = 25'h200;
        ia.ch_wdata[0*16 +: 16] = 16'h5A5A;
        ia.ch_req = 4'b0001;
        observe(5, 1'b0);
        check("rw_wr_cycle",  nth_set(a_wr_v, 0), 32'd1);
        check("rw_busy_w3",   32'(a_busy_v[4]), 32'd1);
        check("rw_no_done",   $countones(a_dn_v), 32'd0);
        rst = 1'b0;
        ia.ch_req = 4'b0000;
        #1;
        check("rw_read",  32'(ia.read), 32'd0);
        check("rw_write", 32'(ia.write), 32'd0);
        check("rw_raddr", 32'(ia.readaddress), 32'd0);
        check("rw_waddr", 32'(ia.writeaddress), 32'd0);
        check("rw_wdata", 32'(ia.writedata), 32'd0);
        check("rw_done",  32'(ia.ch_done), 32'd0);
        check("rw_rdata", 32'(ia.ch_rdata), 32'd0);
        check("rw_busy",  32'(ia.busy), 32'd0);
        align();
        check("rw_done_held", 32'(ia.ch_done), 32'd0);
        rst = 1'b1;
        ia.ch_we = 4'b0000;
        ia.ch_addr[3*25 +: 25] = 25'h77;
        ia.ch_req = 4'b1000;
        observe(6, 1'b1);
        check("rw_post_gid",   32'(a_gid_l[1]), 32'd3);
        check("rw_post_rd",    nth_set(a_rd_v, 0), 32'd1);
        check("rw_post_addr",  32'(a_raddr_l[1]), 32'h77);
        check("rw_post_done",  nth_set(a_dn_v, 0), 32'd3);
        check("rw_post_dval",  32'(a_done_l[3]), 32'h8);

        // Single-channel instance: RD_LAT 3, WR_WAIT 0
        align();
        ib.ch_we = 1'b0;
        ib.ch_addr = 25'h123;
        ib.ch_req = 1'b1;
        observe(8, 1'b1);
        check("b_rd_cycle",  nth_set(b_rd_v, 0), 32'd1);
        check("b_rd_addr",   32'(b_raddr_l[1]), 32'h123);
        check("b_rd_done",   nth_set(b_dn_v, 0), 32'd5);
        check("b_rd_busy",   $countones(b_busy_v), 32'd5);
        check("b_rd_rdata",  32'(b_rdata_l[5]), 32'(mem_val(25'h123)));
        align();
        ib.ch_we = 1'b1;
        ib.ch_addr = 25'h321;
        ib.ch_wdata = 16'hCAFE;
        ib.ch_req = 1'b1;
        observe(5, 1'b1);
        check("b_wr_cycle",  nth_set(b_wr_v, 0), 32'd1);
        check("b_wr_addr",   32'(b_waddr_l[1]), 32'h321);
        check("b_wr_data",   32'(b_wdata_l[1]), 32'hCAFE);
        check("b_wr_done",   nth_set(b_dn_v, 0), 32'd2);
        check("b_wr_busy",   $countones(b_busy_v), 32'd2);

        check("rd_wr_exclusive", both_cnt, 32'd0);
        check("done_onehot",     multi_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/knn_sdram_arbiter.md
KNN_SDRAM_ARBITER -- requirements
Module: knn_sdram_arbiter

Interface
REQ-001 Parameter CH, default 4: number of requester channels, CH >= 1.
REQ-002 Parameter W, default 16: data word width.
REQ-003 Parameter ADDR_W, default 25: SDRAM word address width.
REQ-004 Parameter RD_LAT, default 1: number of cycles after the read pulse until readdata is sampled, RD_LAT >= 1.
REQ-005 Parameter WR_WAIT, default 9: number of busy cycles after the write pulse, WR_WAIT >= 0.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 ch_req  input  CH  per-channel request level; held until that channel's ch_done pulse.
REQ-009 ch_we  input  CH  per-channel direction: 1 = write, 0 = read.
REQ-010 ch_addr  input  CH*ADDR_W  per-channel address, flattened, channel c at [c*ADDR_W +: ADDR_W].
REQ-011 ch_wdata  input  CH*W  per-channel write data, flattened, channel c at [c*W +: W].
REQ-012 ch_done  output  CH  one-cycle completion pulse for the granted channel.
REQ-013 ch_rdata  output  W  last read result; valid in the ch_done cycle of a read, held until the next read completes.
REQ-014 grant_id  output  clog2(CH) (min 1)  index of the channel currently or last served.
REQ-015 busy  output  1  high whenever the state machine is not in IDLE.
REQ-016 read / readaddress / readdata  output 1 / output ADDR_W / input W  SDRAM read port.
REQ-017 write / writeaddress / writedata  output 1 / output ADDR_W / output W  SDRAM write port.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; all outputs SHALL be registered.
REQ-019 In IDLE with any ch_req bit set, the block SHALL grant round-robin starting from pointer p, register the address, data and direction of the winner, set grant_id, and go to ISSUE.
REQ-020 After a grant to channel c, p SHALL become (c+1) mod CH; p SHALL be 0 after reset.
REQ-021 In ISSUE, read or write (per the latched direction) SHALL be high for exactly one cycle, with the address (and, for writes, the data) stable from ISSUE through DONE.
REQ-022 In WAIT, a down-counter SHALL run for RD_LAT cycles (read) or WR_WAIT cycles (write); for WR_WAIT = 0 the FSM SHALL go from ISSUE directly to DONE.
REQ-023 For reads, readdata SHALL be captured into ch_rdata at the rising edge ending the last WAIT cycle.
REQ-024 In DONE, ch_done[grant_id] SHALL be high for one cycle, and the FSM SHALL then go to IDLE.
REQ-025 IDLE SHALL last at least one cycle after DONE, so read and write are low for at least 2 cycles between commands and the served requester has time to drop ch_req.
REQ-026 Read latency from the grant (IDLE) cycle to the ch_done cycle SHALL be RD_LAT+2 cycles; write latency SHALL be WR_WAIT+2 cycles.
REQ-027 read and write SHALL never be high in the same cycle; at most one transaction SHALL be outstanding.
REQ-028 Changes to ch_req, ch_addr or ch_wdata outside IDLE SHALL be ignored until the next IDLE.
REQ-029 With no request in IDLE, the block SHALL stay in IDLE with busy = 0 and p unchanged.

Reset
REQ-030 When rst = 0, the block SHALL immediately force IDLE, p = 0, and read, write, readaddress, writeaddress, writedata, ch_done, ch_rdata, grant_id and busy all to 0.
REQ-031 A reset during ISSUE or WAIT SHALL abort the transaction with no ch_done pulse; the first grant after rst returns to 1 SHALL follow REQ-019.

Verification
REQ-032 Single read: ch_req = 0001, ch_we = 0, ch_addr[0] = 0x40, memory returns 0x1234 one cycle after read -> read pulse at 0x40 in cycle 1, ch_done = 0001 in cycle 3, ch_rdata = 0x1234.
REQ-033 Single write: channel 2 writes 0xBEEF at address 0x100 with WR_WAIT = 9 -> one-cycle write with writeaddress = 0x100 and writedata = 0xBEEF, busy for 11 cycles, ch_done = 0100 in cycle 11.
REQ-034 Fairness: all four ch_req bits held continuously -> grant order 0,1,2,3,0, one ch_done per transaction, never two at once.
REQ-035 Back-to-back spacing: two queued reads -> at least 2 low cycles on read between the pulses; read and write never both high.
REQ-036 Reset mid-write: rst = 0 in the 3rd WAIT cycle -> all outputs 0 in the same cycle, no ch_done; after release, a request on channel 3 is granted first (p = 0 scan reaches 3).
REQ-037 Parameter sweep: CH = 1, RD_LAT = 3, WR_WAIT = 0 -> read latency 5 cycles and write latency 2 cycles, matching REQ-026.
